// File: rtl/direction_ctrl_if.sv
// Button/force inputs and direction outputs between the direction controller and its user.
// The master modport drives the button and force path; the slave modport is the controller.
interface direction_ctrl_if;
    logic btn;
    logic force_en;
    logic force_val;
    logic direction;
    logic btn_clean;
    logic dir_pulse;

    modport master (
        output btn,
        output force_en,
        output force_val,
        input  direction,
        input  btn_clean,
        input  dir_pulse
    );

    modport slave (
        input  btn,
        input  force_en,
        input  force_val,
        output direction,
        output btn_clean,
        output dir_pulse
    );
endinterface

// File: rtl/direction_ctrl.sv
// Push-button to direction level: 2-flop sync, counter debounce FSM, press-edge toggle, force override.
// Latency: btn_clean follows btn DEBOUNCE_CYCLES+2 edges after first sample; no backpressure.
module direction_ctrl #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 8,
    parameter logic INIT_DIR        = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    direction_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             btn_s_q;
    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             btn_clean_q, btn_clean_d;
    logic             direction_q, direction_d;
    logic             dir_pulse_q, dir_pulse_d;
    logic             press_acc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_acc = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (btn_s_q) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PEND_HI: begin
                if (!btn_s_q) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = STABLE_HI;
                    cnt_d     = '0;
                    press_acc = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!btn_s_q) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PEND_LO: begin
                if (btn_s_q) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase

        btn_clean_d = (state_d == STABLE_HI) || (state_d == PEND_LO);

        // Force wins over a same-edge press; that press is dropped, not queued.
        if (bus.force_en) begin
            direction_d = bus.force_val;
            dir_pulse_d = 1'b0;
        end else if (press_acc) begin
            direction_d = ~direction_q;
            dir_pulse_d = 1'b1;
        end else begin
            direction_d = direction_q;
            dir_pulse_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            state_q     <= STABLE_LO;
            cnt_q       <= '0;
            btn_clean_q <= 1'b0;
            direction_q <= INIT_DIR;
            dir_pulse_q <= 1'b0;
        end else begin
            sync1_q     <= bus.btn;
            btn_s_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            btn_clean_q <= btn_clean_d;
            direction_q <= direction_d;
            dir_pulse_q <= dir_pulse_d;
        end
    end

    assign bus.direction = direction_q;
    assign bus.btn_clean = btn_clean_q;
    assign bus.dir_pulse = dir_pulse_q;
endmodule
